// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM sequencer: FSM state encoding,
// address-class limit and the MAC/IP validity rules used on every read.
package eeprom_pkg;

  localparam logic [3:0] ST_PWRUP_ENC   = 4'd0;
  localparam logic [3:0] ST_RD_ENC      = 4'd1;
  localparam logic [3:0] ST_RD_WAIT_ENC = 4'd2;
  localparam logic [3:0] ST_CHECK_ENC   = 4'd3;
  localparam logic [3:0] ST_IDLE_ENC    = 4'd4;
  localparam logic [3:0] ST_WR_ENC      = 4'd5;
  localparam logic [3:0] ST_WR_WAIT_ENC = 4'd6;
  localparam logic [3:0] ST_VERIFY_ENC  = 4'd7;

  typedef enum logic [3:0] {
    ST_PWRUP   = ST_PWRUP_ENC,
    ST_RD      = ST_RD_ENC,
    ST_RD_WAIT = ST_RD_WAIT_ENC,
    ST_CHECK   = ST_CHECK_ENC,
    ST_IDLE    = ST_IDLE_ENC,
    ST_WR      = ST_WR_ENC,
    ST_WR_WAIT = ST_WR_WAIT_ENC,
    ST_VERIFY  = ST_VERIFY_ENC
  } state_t;

  // First octet at or above this value is class D/E and never a usable host address
  localparam logic [7:0] IP_INVALID_HI_OCTET = 8'd224;

  // A usable MAC is neither all-zero nor broadcast and is not a multicast address
  function automatic logic mac_ok(input logic [47:0] m);
    return (m != 48'h0) && (m != {48{1'b1}}) && (m[40] == 1'b0);
  endfunction

  // A usable IP has a first octet in 1..223, which also excludes 0.0.0.0 and broadcast
  function automatic logic ip_ok(input logic [31:0] ip);
    return (ip != 32'h0) && (ip != 32'hFFFF_FFFF) &&
           (ip[31:24] != 8'd0) && (ip[31:24] < IP_INVALID_HI_OCTET);
  endfunction

endpackage

// File: rtl/eeprom_req_arbiter.sv
// Fixed-priority (A over B) selection of IP write requests. Holds the chosen
// requester and its IP until the sequencer signals completion, then steers a
// single-cycle ack with its status back to that requester.
module eeprom_req_arbiter
  import eeprom_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [31:0] ip_a,
  input  logic [31:0] ip_b,
  input  logic        grant_en,
  input  logic        ack_fire,
  input  logic        ack_err,
  output logic        pending,
  output logic [31:0] sel_ip,
  output logic        ack_a,
  output logic        ack_b,
  output logic        wr_err
);

  logic sel_b;

  // Capture a requester when the sequencer is free, release it with an ack when done
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      sel_b   <= 1'b0;
      sel_ip  <= 32'h0;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (grant_en && (req_a || req_b)) begin
        pending <= 1'b1;
        sel_b   <= ~req_a;
        sel_ip  <= req_a ? ip_a : ip_b;
      end else if (ack_fire) begin
        pending <= 1'b0;
        ack_a   <= ~sel_b;
        ack_b   <= sel_b;
        wr_err  <= ack_err;
      end
    end
  end

endmodule

// File: rtl/eeprom_sequencer.sv
// Owns the SPI EEPROM engine: power-up read and publish of MAC/static IP,
// then arbitrated IP writes with a verify re-read. Every engine handshake
// phase is guarded by a timeout that sets a sticky error flag.
module eeprom_sequencer
  import eeprom_pkg::*;
#(
  parameter int POWERUP_DELAY = 1000,
  parameter int TIMEOUT       = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        eep_ready,
  output logic        eep_rd_request,
  output logic        eep_wr_request,
  output logic [31:0] eep_ip_to_write,
  input  logic [47:0] eep_mac,
  input  logic [31:0] eep_ip,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [31:0] ip_a,
  input  logic [31:0] ip_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        wr_err,
  output logic [47:0] mac,
  output logic [31:0] static_ip,
  output logic        mac_valid,
  output logic        ip_valid,
  output logic        config_done,
  output logic        busy,
  output logic        error
);

  state_t      state;
  logic [31:0] cnt;
  logic        holdoff;
  logic [31:0] rd_ip;
  logic        pending;

  logic grant_en;
  logic idle_decide;
  logic reject;
  logic skip;
  logic verify_mismatch;
  logic in_phase;
  logic progress;
  logic timeout_hit;
  logic ack_fire;
  logic ack_err;

  eeprom_req_arbiter u_arbiter (
    .clock    (clock),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .ip_a     (ip_a),
    .ip_b     (ip_b),
    .grant_en (grant_en),
    .ack_fire (ack_fire),
    .ack_err  (ack_err),
    .pending  (pending),
    .sel_ip   (eep_ip_to_write),
    .ack_a    (ack_a),
    .ack_b    (ack_b),
    .wr_err   (wr_err)
  );

  // Decode request decisions, handshake progress and completion from the registered state
  always_comb begin
    grant_en        = (state == ST_IDLE) && !holdoff && !pending;
    idle_decide     = (state == ST_IDLE) && !holdoff && pending;
    reject          = idle_decide && !ip_ok(eep_ip_to_write);
    skip            = idle_decide && ip_ok(eep_ip_to_write) && ip_valid &&
                      (eep_ip_to_write == static_ip);
    verify_mismatch = (rd_ip != eep_ip_to_write);
    in_phase        = 1'b0;
    progress        = 1'b0;
    case (state)
      ST_RD, ST_WR: begin
        in_phase = 1'b1;
        progress = ~eep_ready;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        in_phase = 1'b1;
        progress = eep_ready;
      end
      default: begin
        in_phase = 1'b0;
        progress = 1'b0;
      end
    endcase
    timeout_hit = in_phase && !progress && (cnt == 32'(TIMEOUT - 1));
    ack_fire    = reject || skip || (state == ST_VERIFY) || (timeout_hit && pending);
    ack_err     = reject || ((state == ST_VERIFY) && verify_mismatch) || timeout_hit;
  end

  // Main sequencer: power-up read, publish, write/verify and timeout recovery
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_PWRUP;
      cnt            <= 32'h0;
      holdoff        <= 1'b0;
      rd_ip          <= 32'h0;
      eep_rd_request <= 1'b0;
      eep_wr_request <= 1'b0;
      mac            <= 48'h0;
      static_ip      <= 32'h0;
      mac_valid      <= 1'b0;
      ip_valid       <= 1'b0;
      config_done    <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      cnt     <= cnt + 32'd1;
      holdoff <= ack_fire;
      if (timeout_hit) begin
        error          <= 1'b1;
        eep_rd_request <= 1'b0;
        eep_wr_request <= 1'b0;
        state          <= ST_IDLE;
        busy           <= 1'b0;
        cnt            <= 32'h0;
        if (!pending) begin
          config_done <= 1'b1;
          mac_valid   <= 1'b0;
          ip_valid    <= 1'b0;
        end
      end else begin
        case (state)
          ST_PWRUP: begin
            busy <= 1'b1;
            if (cnt == 32'(POWERUP_DELAY - 1)) begin
              state <= ST_RD;
              cnt   <= 32'h0;
            end
          end
          ST_RD: begin
            if (!eep_ready) begin
              eep_rd_request <= 1'b0;
              state          <= ST_RD_WAIT;
              cnt            <= 32'h0;
            end else begin
              eep_rd_request <= 1'b1;
            end
          end
          ST_RD_WAIT: begin
            if (eep_ready) begin
              state <= ST_CHECK;
              cnt   <= 32'h0;
            end
          end
          ST_CHECK: begin
            mac       <= eep_mac;
            mac_valid <= mac_ok(eep_mac);
            cnt       <= 32'h0;
            if (pending) begin
              rd_ip <= eep_ip;
              state <= ST_VERIFY;
            end else begin
              static_ip   <= eep_ip;
              ip_valid    <= ip_ok(eep_ip);
              config_done <= 1'b1;
              state       <= ST_IDLE;
              busy        <= 1'b0;
            end
          end
          ST_IDLE: begin
            if (idle_decide && !reject && !skip) begin
              state <= ST_WR;
              busy  <= 1'b1;
              cnt   <= 32'h0;
            end
          end
          ST_WR: begin
            if (!eep_ready) begin
              eep_wr_request <= 1'b0;
              state          <= ST_WR_WAIT;
              cnt            <= 32'h0;
            end else begin
              eep_wr_request <= 1'b1;
            end
          end
          ST_WR_WAIT: begin
            if (eep_ready) begin
              state <= ST_RD;
              cnt   <= 32'h0;
            end
          end
          ST_VERIFY: begin
            if (!verify_mismatch) begin
              static_ip <= eep_ip_to_write;
              ip_valid  <= ip_ok(eep_ip_to_write);
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= 32'h0;
          end
          default: begin
            state <= ST_PWRUP;
            cnt   <= 32'h0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeprom_sequencer.sv
// Directed bench for eeprom_sequencer with a small behavioural EEPROM engine.
module tb_eeprom_sequencer;

  localparam int PD = 16;
  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        eep_rd_request, eep_wr_request;
  logic [31:0] eep_ip_to_write;
  logic [47:0] eep_mac;
  logic [31:0] eep_ip;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] ip_a = 32'h0, ip_b = 32'h0;
  logic        ack_a, ack_b, wr_err;
  logic [47:0] mac;
  logic [31:0] static_ip;
  logic        mac_valid, ip_valid, config_done, busy, error;

  // engine model state
  logic        eep_ready   = 1'b1;
  int          eng_cnt     = 0;
  logic        eng_is_wr   = 1'b0;
  logic [31:0] wr_latched  = 32'h0;
  logic [31:0] mem_ip      = 32'h0;
  logic [47:0] mem_mac     = 48'h0;
  int          wr_count    = 0;
  int          ack_count   = 0;
  logic        eng_stuck   = 1'b0;
  logic        corrupt     = 1'b0;
  logic        preload     = 1'b0;
  logic [31:0] preload_ip  = 32'h0;
  logic [47:0] preload_mac = 48'h0;

  int errors = 0;
  int checks = 0;
  int n;
  int wr_before;
  int ack_before;

  localparam logic [47:0] GOOD_MAC = 48'h001C_C0A2_13DD;
  localparam logic [31:0] GOOD_IP  = 32'hC0A8_0132;

  assign eep_mac = mem_mac;
  assign eep_ip  = corrupt ? (mem_ip ^ 32'h1) : mem_ip;

  eeprom_sequencer #(.POWERUP_DELAY(PD), .TIMEOUT(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .eep_ready       (eep_ready),
    .eep_rd_request  (eep_rd_request),
    .eep_wr_request  (eep_wr_request),
    .eep_ip_to_write (eep_ip_to_write),
    .eep_mac         (eep_mac),
    .eep_ip          (eep_ip),
    .req_a           (req_a),
    .req_b           (req_b),
    .ip_a            (ip_a),
    .ip_b            (ip_b),
    .ack_a           (ack_a),
    .ack_b           (ack_b),
    .wr_err          (wr_err),
    .mac             (mac),
    .static_ip       (static_ip),
    .mac_valid       (mac_valid),
    .ip_valid        (ip_valid),
    .config_done     (config_done),
    .busy            (busy),
    .error           (error)
  );

  always #5 clock = ~clock;

  // Engine: drops ready one cycle after a request, stays busy 5 cycles, stores writes
  always @(posedge clock) begin
    if (preload) begin
      mem_ip  <= preload_ip;
      mem_mac <= preload_mac;
    end
    if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eep_ready <= 1'b1;
        if (eng_is_wr) mem_ip <= wr_latched;
      end
    end else if (eep_ready && !eng_stuck && (eep_rd_request || eep_wr_request)) begin
      eep_ready  <= 1'b0;
      eng_cnt    <= 5;
      eng_is_wr  <= eep_wr_request;
      wr_latched <= eep_ip_to_write;
      if (eep_wr_request) wr_count <= wr_count + 1;
    end
  end

  // Count every ack pulse the DUT emits
  always @(posedge clock) begin
    if (ack_a || ack_b) ack_count <= ack_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic [31:0] ipa,
                               input logic b, input logic [31:0] ipb);
    @(negedge clock);
    req_a = a;
    ip_a  = ipa;
    req_b = b;
    ip_b  = ipb;
  endtask

  task automatic resetDut(input logic load, input logic [47:0] m, input logic [31:0] ip);
    @(negedge clock);
    reset       = 1'b1;
    req_a       = 1'b0;
    req_b       = 1'b0;
    preload_mac = m;
    preload_ip  = ip;
    preload     = load;
    @(negedge clock);
    preload = 1'b0;
  endtask

  task automatic releaseReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitRdRequest(output int cycles);
    cycles = 0;
    do begin
      @(posedge clock); #1; cycles++;
    end while (eep_rd_request !== 1'b1 && cycles < 300);
  endtask

  task automatic waitConfig();
    int c;
    c = 0;
    do begin
      @(posedge clock); #1; c++;
    end while (config_done !== 1'b1 && c < 300);
    checkOutput("config_done_seen", config_done, 1'b1);
  endtask

  task automatic waitAck(input logic use_b, output int cycles);
    cycles = 0;
    do begin
      @(posedge clock); #1; cycles++;
    end while (((use_b ? ack_b : ack_a) !== 1'b1) && cycles < 400);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_config_done", config_done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rd_req", eep_rd_request, 1'b0);
    checkOutput("rst_mac", mac, 48'h0);
    checkOutput("rst_static_ip", static_ip, 32'h0);
    checkOutput("rst_error", error, 1'b0);

    // good power-up read
    resetDut(1'b1, GOOD_MAC, GOOD_IP);
    releaseReset();
    waitRdRequest(n);
    checkOutput("pwrup_rd_latency", n, PD + 1);
    waitConfig();
    @(posedge clock); #1;
    checkOutput("cfg_mac", mac, GOOD_MAC);
    checkOutput("cfg_ip", static_ip, GOOD_IP);
    checkOutput("cfg_mac_valid", mac_valid, 1'b1);
    checkOutput("cfg_ip_valid", ip_valid, 1'b1);
    checkOutput("cfg_busy", busy, 1'b0);
    checkOutput("cfg_error", error, 1'b0);

    // invalid stored values are published with valid bits low
    resetDut(1'b1, {48{1'b1}}, 32'hFFFF_FFFF);
    releaseReset();
    wr_before = wr_count;
    waitConfig();
    repeat (10) @(posedge clock);
    #1;
    checkOutput("bad_ip_valid", ip_valid, 1'b0);
    checkOutput("bad_mac_valid", mac_valid, 1'b0);
    checkOutput("bad_static_ip", static_ip, 32'hFFFF_FFFF);
    checkOutput("bad_no_write", wr_count - wr_before, 0);

    // back to a good configuration
    resetDut(1'b1, GOOD_MAC, GOOD_IP);
    releaseReset();
    waitConfig();

    // simultaneous requests: A first, then B
    wr_before = wr_count;
    applyStimulus(1'b1, 32'h0A00_0005, 1'b1, 32'h0A00_0006);
    waitAck(1'b0, n);
    checkOutput("both_ack_a", ack_a, 1'b1);
    checkOutput("both_ack_b_quiet", ack_b, 1'b0);
    checkOutput("both_a_wr_err", wr_err, 1'b0);
    checkOutput("both_a_ip", static_ip, 32'h0A00_0005);
    req_a = 1'b0;
    @(posedge clock); #1;
    checkOutput("both_ack_a_pulse", ack_a, 1'b0);
    waitAck(1'b1, n);
    checkOutput("both_ack_b", ack_b, 1'b1);
    checkOutput("both_b_wr_err", wr_err, 1'b0);
    req_b = 1'b0;
    checkOutput("both_final_ip", static_ip, 32'h0A00_0006);
    checkOutput("both_ip_valid", ip_valid, 1'b1);
    checkOutput("both_writes", wr_count - wr_before, 2);

    // rejected request
    repeat (3) @(negedge clock);
    wr_before = wr_count;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    waitAck(1'b1, n);
    req_b = 1'b0;
    checkOutput("rej_latency", n, 2);
    checkOutput("rej_wr_err", wr_err, 1'b1);
    checkOutput("rej_no_write", wr_count - wr_before, 0);

    // request equal to current IP is skipped
    repeat (3) @(negedge clock);
    wr_before = wr_count;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0A00_0006);
    waitAck(1'b1, n);
    req_b = 1'b0;
    checkOutput("skip_latency", n, 2);
    checkOutput("skip_wr_err", wr_err, 1'b0);
    checkOutput("skip_no_write", wr_count - wr_before, 0);

    // engine never responds to a write
    repeat (3) @(negedge clock);
    eng_stuck = 1'b1;
    applyStimulus(1'b1, 32'h0A00_0007, 1'b0, 32'h0);
    waitAck(1'b0, n);
    req_a = 1'b0;
    checkOutput("to_ack_a", ack_a, 1'b1);
    checkOutput("to_wr_err", wr_err, 1'b1);
    checkOutput("to_error", error, 1'b1);
    checkOutput("to_busy", busy, 1'b0);
    checkOutput("to_wr_req", eep_wr_request, 1'b0);
    checkOutput("to_ip_kept", static_ip, 32'h0A00_0006);
    @(negedge clock);
    eng_stuck = 1'b0;

    // verify read returns a corrupted IP
    repeat (3) @(negedge clock);
    corrupt = 1'b1;
    applyStimulus(1'b1, 32'h0A00_0008, 1'b0, 32'h0);
    waitAck(1'b0, n);
    req_a = 1'b0;
    checkOutput("vfy_ack_a", ack_a, 1'b1);
    checkOutput("vfy_wr_err", wr_err, 1'b1);
    checkOutput("vfy_ip_kept", static_ip, 32'h0A00_0006);
    checkOutput("vfy_ip_valid", ip_valid, 1'b1);
    checkOutput("vfy_mac", mac, GOOD_MAC);
    checkOutput("vfy_error_sticky", error, 1'b1);
    @(negedge clock);
    corrupt = 1'b0;

    // reset while the write is in flight
    repeat (3) @(negedge clock);
    applyStimulus(1'b1, 32'h0A00_000A, 1'b0, 32'h0);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (eep_wr_request !== 1'b1 && n < 100);
    checkOutput("mid_wr_req_rise", eep_wr_request, 1'b1);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (eep_wr_request !== 1'b0 && n < 100);
    checkOutput("mid_wr_req_fall", eep_wr_request, 1'b0);
    ack_before = ack_count;
    resetDut(1'b0, 48'h0, 32'h0);
    #1;
    checkOutput("mid_rd_req_drop", eep_rd_request, 1'b0);
    checkOutput("mid_wr_req_drop", eep_wr_request, 1'b0);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_config_done", config_done, 1'b0);
    checkOutput("mid_ack_a", ack_a, 1'b0);
    releaseReset();
    waitRdRequest(n);
    checkOutput("mid_rd_latency", n, PD + 1);
    waitConfig();
    @(posedge clock); #1;
    checkOutput("mid_reread_ip", static_ip, 32'h0A00_000A);
    checkOutput("mid_reread_valid", ip_valid, 1'b1);
    checkOutput("mid_error_cleared", error, 1'b0);
    checkOutput("mid_no_ack", ack_count - ack_before, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
